// File: rtl/discrete_values_table_loader.sv
// Run-time loader for the discrete values table: takes a header and then that many range entries,
// and turns them into table write strobes plus one choice-count write per variable.
module discrete_values_table_loader #(
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
  parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 8,
  parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 4
) (
  input  logic                                                                  in_clock,
  input  logic                                                                  in_reset_n,
  input  logic                                                                  in_header_valid,
  output logic                                                                  out_header_ready,
  input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]                           in_variable_index,
  input  logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES:0]                            in_number_of_choices,
  input  logic                                                                  in_value_valid,
  output logic                                                                  out_value_ready,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]                          in_start,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]                          in_end,
  input  logic                                                                  in_abort,
  output logic                                                                  out_write_enable,
  output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX+MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0] out_write_address,
  output logic [2*MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]                        out_write_data,
  output logic                                                                  out_count_write_enable,
  output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]                           out_count_variable_index,
  output logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES:0]                            out_number_of_choices,
  output logic                                                                  out_done,
  output logic                                                                  out_error
);

  localparam int W = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int V = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
  localparam int C = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
  localparam logic [C:0] MAX_CHOICES = {1'b1, {C{1'b0}}};

  typedef enum logic [0:0] {IDLE, LOAD} state_t;

  state_t         state, state_nx;
  logic [V-1:0]   var_idx;
  logic [C:0]     count;
  logic [C-1:0]   count_m1;
  logic [C-1:0]   choice_cnt;

  logic           hdr_legal_p0;
  logic           hdr_acc_p0;
  logic           val_acc_p0;
  logic           last_p0;

  logic           wr_en_p1;
  logic [V+C-1:0] wr_addr_p1;
  logic [2*W-1:0] wr_data_p1;
  logic           cnt_wr_p1;
  logic [V-1:0]   cnt_var_p1;
  logic [C:0]     cnt_num_p1;
  logic           done_p1;
  logic           error_p1;

  // Inverted ranges are stored swapped so the table always holds {low, high}.
  function automatic logic [2*W-1:0] order_range(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a <= b) ? {a, b} : {b, a};
  endfunction

  assign hdr_legal_p0 = (in_number_of_choices != '0) && (in_number_of_choices <= MAX_CHOICES);

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    hdr_acc_p0 = 1'b0;
    val_acc_p0 = 1'b0;
    last_p0    = 1'b0;
    if (in_abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (in_header_valid) begin
          hdr_acc_p0 = 1'b1;
          if (hdr_legal_p0) state_nx = LOAD;
        end
        LOAD: if (in_value_valid) begin
          val_acc_p0 = 1'b1;
          last_p0    = (choice_cnt == count_m1);
          if (last_p0) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Readies depend on state only; reset forces them low while it is asserted.
  assign out_header_ready = in_reset_n && (state == IDLE);
  assign out_value_ready  = in_reset_n && (state == LOAD);

  // p0 -> p1: accepted header/entry registered into table and count writes
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      var_idx    <= '0;
      count      <= '0;
      count_m1   <= '0;
      choice_cnt <= '0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      cnt_wr_p1  <= 1'b0;
      cnt_var_p1 <= '0;
      cnt_num_p1 <= '0;
      done_p1    <= 1'b0;
      error_p1   <= 1'b0;
    end else begin
      wr_en_p1  <= val_acc_p0;
      cnt_wr_p1 <= val_acc_p0 && last_p0;
      done_p1   <= val_acc_p0 && last_p0;
      if (in_abort) choice_cnt <= '0;
      if (hdr_acc_p0) begin
        if (hdr_legal_p0) begin
          var_idx    <= in_variable_index;
          count      <= in_number_of_choices;
          count_m1   <= C'(in_number_of_choices - 1'b1);
          choice_cnt <= '0;
        end else begin
          error_p1 <= 1'b1;
        end
      end
      if (val_acc_p0) begin
        wr_addr_p1 <= {var_idx, choice_cnt};
        wr_data_p1 <= order_range(in_start, in_end);
        choice_cnt <= last_p0 ? '0 : choice_cnt + 1'b1;
        if (last_p0) begin
          cnt_var_p1 <= var_idx;
          cnt_num_p1 <= count;
        end
      end
    end
  end

  assign out_write_enable         = wr_en_p1;
  assign out_write_address        = wr_addr_p1;
  assign out_write_data           = wr_data_p1;
  assign out_count_write_enable   = cnt_wr_p1;
  assign out_count_variable_index = cnt_var_p1;
  assign out_number_of_choices    = cnt_num_p1;
  assign out_done                 = done_p1;
  assign out_error                = error_p1;

endmodule

// File: tb/tb_discrete_values_table_loader.sv
// Randomized self-checking bench for discrete_values_table_loader against a transaction-level model.
module tb_discrete_values_table_loader;

  logic        in_clock;
  logic        in_reset_n;
  logic        in_header_valid;
  logic        out_header_ready;
  logic [7:0]  in_variable_index;
  logic [4:0]  in_number_of_choices;
  logic        in_value_valid;
  logic        out_value_ready;
  logic [7:0]  in_start;
  logic [7:0]  in_end;
  logic        in_abort;
  logic        out_write_enable;
  logic [11:0] out_write_address;
  logic [15:0] out_write_data;
  logic        out_count_write_enable;
  logic [7:0]  out_count_variable_index;
  logic [4:0]  out_number_of_choices;
  logic        out_done;
  logic        out_error;

  discrete_values_table_loader #(
    .MAX_BIT_WIDTH_OF_INTEGER_VARIABLE(8),
    .MAX_BIT_WIDTH_OF_VARIABLES_INDEX(8),
    .MAX_BIT_WIDTH_OF_DISCRETE_CHOICES(4)
  ) dut (
    .in_clock(in_clock),
    .in_reset_n(in_reset_n),
    .in_header_valid(in_header_valid),
    .out_header_ready(out_header_ready),
    .in_variable_index(in_variable_index),
    .in_number_of_choices(in_number_of_choices),
    .in_value_valid(in_value_valid),
    .out_value_ready(out_value_ready),
    .in_start(in_start),
    .in_end(in_end),
    .in_abort(in_abort),
    .out_write_enable(out_write_enable),
    .out_write_address(out_write_address),
    .out_write_data(out_write_data),
    .out_count_write_enable(out_count_write_enable),
    .out_count_variable_index(out_count_variable_index),
    .out_number_of_choices(out_number_of_choices),
    .out_done(out_done),
    .out_error(out_error)
  );

  initial begin
    in_clock = 1'b0;
    forever #5 in_clock = ~in_clock;
  end

  int n_vec;
  int n_err;
  int n_done_seen;

  // Reference model: a load in progress is a variable, a count, and how many entries are already stored.
  bit m_load;
  bit m_err;
  int m_var;
  int m_cnt;
  int m_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hdr_rdy"}, out_header_ready, 0);
    check({tag, "_val_rdy"}, out_value_ready, 0);
    check({tag, "_we"},      out_write_enable, 0);
    check({tag, "_addr"},    out_write_address, 0);
    check({tag, "_data"},    out_write_data, 0);
    check({tag, "_cwe"},     out_count_write_enable, 0);
    check({tag, "_cvar"},    out_count_variable_index, 0);
    check({tag, "_cnum"},    out_number_of_choices, 0);
    check({tag, "_done"},    out_done, 0);
    check({tag, "_error"},   out_error, 0);
  endtask

  task automatic step(input bit hv, input int vi, input int nc, input bit vv,
                      input int s, input int e, input bit ab);
    bit x_we, x_cwe;
    int x_addr, x_data, x_cvar, x_cnum;
    in_header_valid      = hv;
    in_variable_index    = vi[7:0];
    in_number_of_choices = nc[4:0];
    in_value_valid       = vv;
    in_start             = s[7:0];
    in_end               = e[7:0];
    in_abort             = ab;
    #1;
    check("hdr_rdy", out_header_ready, !m_load);
    check("val_rdy", out_value_ready, m_load);
    x_we = 0; x_cwe = 0; x_addr = 0; x_data = 0; x_cvar = 0; x_cnum = 0;
    if (ab) begin
      m_load = 0;
      m_idx  = 0;
    end else if (!m_load && hv) begin
      if (nc >= 1 && nc <= 16) begin
        m_load = 1; m_var = vi; m_cnt = nc; m_idx = 0;
      end else begin
        m_err = 1;
      end
    end else if (m_load && vv) begin
      x_we   = 1;
      x_addr = m_var * 16 + m_idx;
      x_data = (s <= e) ? (s * 256 + e) : (e * 256 + s);
      m_idx++;
      if (m_idx == m_cnt) begin
        x_cwe  = 1;
        x_cvar = m_var;
        x_cnum = m_cnt;
        m_load = 0;
        m_idx  = 0;
      end
    end
    @(posedge in_clock);
    #1;
    check("we", out_write_enable, x_we);
    check("cwe", out_count_write_enable, x_cwe);
    check("done", out_done, x_cwe);
    check("error", out_error, m_err);
    if (x_we) begin
      check("addr", out_write_address, x_addr);
      check("data", out_write_data, x_data);
    end
    if (x_cwe) begin
      check("cvar", out_count_variable_index, x_cvar);
      check("cnum", out_number_of_choices, x_cnum);
    end
    if (out_done) n_done_seen++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset is applied between clock edges to exercise its asynchronous behaviour.
  task automatic do_reset(input string tag);
    #2;
    in_reset_n = 1'b0;
    #1;
    check_all_zero(tag);
    m_load = 0; m_err = 0; m_idx = 0;
    #3;
    in_reset_n = 1'b1;
  endtask

  task automatic load_random(input int nvar, input int ncnt);
    step(1, nvar, ncnt, 0, 0, 0, 0);
    for (int i = 0; i < ncnt; i++)
      step(0, 0, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255), 0);
  endtask

  initial begin
    int d0;
    n_vec = 0; n_err = 0; n_done_seen = 0;
    m_load = 0; m_err = 0; m_var = 0; m_cnt = 0; m_idx = 0;
    in_reset_n = 1'b0;
    in_header_valid = 0; in_variable_index = 0; in_number_of_choices = 0;
    in_value_valid = 0; in_start = 0; in_end = 0; in_abort = 0;
    #3;
    check_all_zero("por");
    #9;
    in_reset_n = 1'b1;
    @(posedge in_clock);
    #1;
    check("hdr_rdy_after_rst", out_header_ready, 1);

    // Two-entry load with one inverted range.
    step(1, 3, 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 9, 0);
    check("t1_addr0", out_write_address, 12'h030);
    check("t1_data0", out_write_data, 16'h0509);
    step(0, 0, 0, 1, 20, 10, 0);
    check("t1_addr1", out_write_address, 12'h031);
    check("t1_data1", out_write_data, 16'h0A14);
    idle();

    // Full 16-entry variable back-to-back, then a header right after the last entry.
    d0 = n_done_seen;
    load_random(255, 16);
    check("t2_last_addr", out_write_address, 12'hFFF);
    check("t2_one_done", n_done_seen - d0, 1);
    load_random(7, 1);
    idle();

    // Illegal counts set the sticky error and leave the loader idle.
    step(1, 9, 0, 0, 0, 0, 0);
    step(1, 9, 17, 1, 1, 2, 0);
    idle();
    check("t3_error_sticky", out_error, 1);

    // Abort after one of three entries, then a new header immediately.
    step(1, 4, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 33, 44, 0);
    step(1, 0, 0, 1, 55, 66, 1);
    load_random(5, 2);

    // Valid held on the channel that is not ready.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 2, 0);
    step(1, 12, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 13, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 200, 100, 0);
    step(0, 0, 0, 1, 0, 255, 0);
    idle();

    // Reset in the middle of a load; also clears the sticky error.
    step(1, 21, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 4, 0);
    step(0, 0, 0, 1, 8, 6, 0);
    do_reset("midrst");
    idle();
    load_random(22, 3);

    // Randomized traffic with occasional illegal headers, aborts and one reset.
    for (int i = 0; i < 3000; i++) begin
      int nc;
      if ($urandom_range(0, 19) == 0)
        nc = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31);
      else
        nc = $urandom_range(1, 16);
      if (i == 1500) do_reset("rndrst");
      step($urandom_range(0, 1), $urandom_range(0, 255), nc, $urandom_range(0, 3) != 0,
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 39) == 0);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
